conv2d_mc_with_mem: RTL and testbench
=====================================

# conv2d_mc_with_mem

Multi-channel, strided 2-D convolution engine with a shared single-port memory bus. On `start` it fetches a `C_IN`-channel input tensor and matching kernel stack, then computes each output pixel as the sum over channels of a K×K window MAC. Each result is post-processed (arithmetic shift, optional ReLU) and written back to memory. It is the next generation of the single-channel near-memory convolution block and sits on the same `mem_sel`/`mem_w`/`ready` bus as the memory controller.

## Interface
- `MAT_WIDTH`, 8, signed input element width
- `K_WIDTH`, 8, signed kernel element width
- `ADDR_WIDTH`, 8, address bus width
- `DATABUS_WIDTH`, 32, data bus width
- `ACC_WIDTH`, 32, signed accumulator width
- `HEIGHT`, 4, input rows per channel
- `WIDTH`, 4, input columns per channel
- `K`, 2, kernel side
- `C_IN`, 2, input channels (≥1)
- `STRIDE`, 1, window step in x and y (≥1)
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: begin job; sampled only in IDLE
- `matrix_addr` in ADDR_WIDTH: input tensor base
- `kernel_addr` in ADDR_WIDTH: kernel stack base
- `output_addr` in ADDR_WIDTH: output base
- `shift` in 5: arithmetic right shift applied to the result; latched at start
- `relu_en` in 1: clamp negative results to 0; latched at start
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse when the final write completes
- `mem_w` out 1: write strobe
- `mem_sel` out 1: bus request
- `address_bus` inout ADDR_WIDTH: driven only while `mem_sel`=1, Z otherwise
- `data_bus` inout DATABUS_WIDTH: driven only while `mem_sel`=1 and `mem_w`=1, Z otherwise
- `ready` in 1: memory completion; read data is valid on `data_bus` in the same cycle

## Operation
- Derived values: OUT_H=(HEIGHT-K)/STRIDE+1 and OUT_W=(WIDTH-K)/STRIDE+1, using integer division.
- Memory layout is channel-major, row-major:
  - input element (c,r,col) at matrix_addr + c·HEIGHT·WIDTH + r·WIDTH + col
  - kernel element (c,i,j) at kernel_addr + c·K·K + i·K + j
  - output (oy,ox) at output_addr + oy·OUT_W + ox
  - all address arithmetic wraps modulo 2^ADDR_WIDTH
- State machine:
  - IDLE → (start) LOAD_MAT
  - LOAD_MAT → (last of C_IN·HEIGHT·WIDTH reads) LOAD_KERN
  - LOAD_KERN → (last of C_IN·K·K reads) COMPUTE
  - COMPUTE → (last of C_IN·K·K MACs) WRITE
  - WRITE → (ready) COMPUTE if more pixels remain, else DONE
  - DONE → IDLE, with `done`=1 for exactly that one cycle
- Reads capture the low MAT_WIDTH or K_WIDTH bits of `data_bus`, interpreted as signed.
- MAC: the signed product is sign-extended to ACC_WIDTH and added to the accumulator. Accumulation wraps modulo 2^ACC_WIDTH with no saturation.
- Post-processing:
  - r = acc >>> shift
  - if relu_en and r<0, then r=0
  - r is sign-extended or truncated to DATABUS_WIDTH
- The window origin is (oy·STRIDE, ox·STRIDE). Pixel order is raster: ox is the inner loop. MAC order is c, then i, then j, with j as the inner loop.
- `start` while busy is ignored. `matrix_addr`, `kernel_addr`, `output_addr`, `shift` and `relu_en` are latched at start; later changes have no effect on the running job.
- Reset at any time, including mid-transfer:
  - `mem_sel`=`mem_w`=`done`=`busy`=0
  - both buses Z
  - state IDLE and all counters 0
  - no write completes and no `done` pulse is produced
  - internal buffers need not be cleared.

## Timing
- Reset values: `done`=0, `busy`=0, `mem_sel`=0, `mem_w`=0, internal address 0, internal data 0.
- Bus transaction:
  - `mem_sel` rises the cycle after entering a load or write slot. For writes, `mem_w`=1 together with `mem_sel`.
  - Address and data stay stable until a cycle with `ready`=1.
  - In the cycle after `ready`, `mem_sel` and `mem_w` are 0 (one mandatory gap cycle). The next request follows after that gap.
  - `ready` while `mem_sel`=0 is ignored.
- With zero-wait memory (ready tied high): each access takes 2 cycles, and each output pixel takes C_IN·K·K MAC cycles plus 2 write cycles.
- `busy` rises the cycle after `start` is sampled. `busy` falls in the same cycle that `done` pulses.

## Test plan
- Single channel (C_IN=1, STRIDE=1, 4×4 input 1..16 row-major, 2×2 kernel all 1, shift=0, relu_en=0): writes 14,18,22,30,34,38,46,50,54 to output_addr..+8, then one `done` pulse.
- C_IN=2: channel 0 as in the previous test, channel 1 all 1, both kernels all 1 → outputs 18,22,26,34,38,42,50,54,58.
- STRIDE=2 with the single-channel data → exactly 4 writes: 14,22,46,54.
- Kernel all −1, single-channel data:
  - relu_en=0 → first write 0xFFFFFFF2
  - relu_en=1 → all nine writes 0
  - shift=2 with the all-1 kernel → first write 3
- `ready` held low 3 cycles on every access → `mem_sel`, address and write data stay stable. Results match the zero-wait run, and a gap cycle follows every completed access.
- Assert `rst` mid-COMPUTE → the bus goes Z and `busy`=0 immediately, with no further writes. Assert `start` during a job → ignored. A fresh `start` after the reset produces correct results.

Source files
------------

// File: rtl/conv2d_mc_with_mem.sv
// Multi-channel strided 2-D convolution engine sharing a single-port memory bus.
// Fetches C_IN input planes and the kernel stack, then MACs and writes each output pixel.
module conv2d_mc_with_mem #(
    parameter int MAT_WIDTH     = 8,
    parameter int K_WIDTH       = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATABUS_WIDTH = 32,
    parameter int ACC_WIDTH     = 32,
    parameter int HEIGHT        = 4,
    parameter int WIDTH         = 4,
    parameter int K             = 2,
    parameter int C_IN          = 2,
    parameter int STRIDE        = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    matrix_addr,
    input  logic [ADDR_WIDTH-1:0]    kernel_addr,
    input  logic [ADDR_WIDTH-1:0]    output_addr,
    input  logic [4:0]               shift,
    input  logic                     relu_en,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_w,
    output logic                     mem_sel,
    inout  wire  [ADDR_WIDTH-1:0]    address_bus,
    inout  wire  [DATABUS_WIDTH-1:0] data_bus,
    input  logic                     ready
);
    localparam int OUT_H  = (HEIGHT - K) / STRIDE + 1;
    localparam int OUT_W  = (WIDTH - K) / STRIDE + 1;
    localparam int N_MAT  = C_IN * HEIGHT * WIDTH;
    localparam int N_KERN = C_IN * K * K;
    localparam int N_PIX  = OUT_H * OUT_W;
    localparam int MI_W   = (N_MAT > 1) ? $clog2(N_MAT) : 1;
    localparam int KI_W   = (N_KERN > 1) ? $clog2(N_KERN) : 1;
    localparam int PW     = MAT_WIDTH + K_WIDTH;
    localparam int CW     = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_MAT  = 3'd1,
        S_LOAD_KERN = 3'd2,
        S_COMPUTE   = 3'd3,
        S_WRITE     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                      state_r;
    logic                        busy_r, done_r, mem_sel_r, mem_w_r;
    logic [ADDR_WIDTH-1:0]       address_r, mat_base_r, kern_base_r, out_base_r;
    logic [DATABUS_WIDTH-1:0]    data_r;
    logic [4:0]                  shift_r;
    logic                        relu_r;
    logic [CW-1:0]               load_cnt_r, mac_cnt_r, pix_cnt_r;
    logic [CW-1:0]               c_r, i_r, j_r, ox_r, oy_r;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [MAT_WIDTH-1:0] mat_buf_r [N_MAT];
    logic signed [K_WIDTH-1:0]   kern_buf_r [N_KERN];

    logic [31:0]                 row_s, col_s;
    logic [MI_W-1:0]             mat_idx_s;
    logic signed [MAT_WIDTH-1:0] mat_val_s;
    logic signed [K_WIDTH-1:0]   kern_val_s;
    logic signed [PW-1:0]        prod_s;
    logic signed [ACC_WIDTH-1:0] prod_ext_s;

    // Shift, optional clamp of negatives, then resize to the bus width keeping the sign.
    function automatic logic [DATABUS_WIDTH-1:0] post_fn(input logic signed [ACC_WIDTH-1:0] acc_v,
                                                         input logic [4:0] sh_v,
                                                         input logic relu_v);
        logic signed [ACC_WIDTH-1:0] res_v;
        res_v = acc_v >>> sh_v;
        if (relu_v && res_v[ACC_WIDTH-1]) begin
            res_v = {ACC_WIDTH{1'b0}};
        end else begin
            res_v = res_v;
        end
        return DATABUS_WIDTH'(res_v);
    endfunction

    assign busy        = busy_r;
    assign done        = done_r;
    assign mem_sel     = mem_sel_r;
    assign mem_w       = mem_w_r;
    assign address_bus = mem_sel_r ? address_r : {ADDR_WIDTH{1'bz}};
    assign data_bus    = (mem_sel_r && mem_w_r) ? data_r : {DATABUS_WIDTH{1'bz}};

    // Current MAC operands: window origin plus (i,j) offset inside channel c.
    always_comb begin
        row_s      = 32'(oy_r) * 32'(STRIDE) + 32'(i_r);
        col_s      = 32'(ox_r) * 32'(STRIDE) + 32'(j_r);
        mat_idx_s  = MI_W'(32'(c_r) * 32'(HEIGHT * WIDTH) + row_s * 32'(WIDTH) + col_s);
        mat_val_s  = mat_buf_r[mat_idx_s];
        kern_val_s = kern_buf_r[mac_cnt_r[KI_W-1:0]];
        prod_s     = mat_val_s * kern_val_s;
        prod_ext_s = {{(ACC_WIDTH - PW){prod_s[PW-1]}}, prod_s};
    end

    // Local copies of the tensor and kernels, filled as read data returns.
    always_ff @(posedge clk) begin
        if (state_r == S_LOAD_MAT && mem_sel_r && ready) begin
            mat_buf_r[load_cnt_r[MI_W-1:0]] <= data_bus[MAT_WIDTH-1:0];
        end
        if (state_r == S_LOAD_KERN && mem_sel_r && ready) begin
            kern_buf_r[load_cnt_r[KI_W-1:0]] <= data_bus[K_WIDTH-1:0];
        end
    end

    // Control FSM: each bus slot spends one idle cycle before raising mem_sel, which
    // doubles as the mandatory gap after the previous access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mem_sel_r   <= 1'b0;
            mem_w_r     <= 1'b0;
            address_r   <= {ADDR_WIDTH{1'b0}};
            data_r      <= {DATABUS_WIDTH{1'b0}};
            mat_base_r  <= {ADDR_WIDTH{1'b0}};
            kern_base_r <= {ADDR_WIDTH{1'b0}};
            out_base_r  <= {ADDR_WIDTH{1'b0}};
            shift_r     <= 5'd0;
            relu_r      <= 1'b0;
            load_cnt_r  <= {CW{1'b0}};
            mac_cnt_r   <= {CW{1'b0}};
            pix_cnt_r   <= {CW{1'b0}};
            c_r         <= {CW{1'b0}};
            i_r         <= {CW{1'b0}};
            j_r         <= {CW{1'b0}};
            ox_r        <= {CW{1'b0}};
            oy_r        <= {CW{1'b0}};
            acc_r       <= {ACC_WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        mat_base_r  <= matrix_addr;
                        kern_base_r <= kernel_addr;
                        out_base_r  <= output_addr;
                        shift_r     <= shift;
                        relu_r      <= relu_en;
                        busy_r      <= 1'b1;
                        load_cnt_r  <= {CW{1'b0}};
                        mac_cnt_r   <= {CW{1'b0}};
                        pix_cnt_r   <= {CW{1'b0}};
                        c_r         <= {CW{1'b0}};
                        i_r         <= {CW{1'b0}};
                        j_r         <= {CW{1'b0}};
                        ox_r        <= {CW{1'b0}};
                        oy_r        <= {CW{1'b0}};
                        state_r     <= S_LOAD_MAT;
                    end
                end
                S_LOAD_MAT: begin
                    if (!mem_sel_r) begin
                        mem_sel_r <= 1'b1;
                        address_r <= mat_base_r + ADDR_WIDTH'(load_cnt_r);
                    end else if (ready) begin
                        mem_sel_r <= 1'b0;
                        if (load_cnt_r == CW'(N_MAT - 1)) begin
                            load_cnt_r <= {CW{1'b0}};
                            state_r    <= S_LOAD_KERN;
                        end else begin
                            load_cnt_r <= load_cnt_r + 16'd1;
                        end
                    end
                end
                S_LOAD_KERN: begin
                    if (!mem_sel_r) begin
                        mem_sel_r <= 1'b1;
                        address_r <= kern_base_r + ADDR_WIDTH'(load_cnt_r);
                    end else if (ready) begin
                        mem_sel_r <= 1'b0;
                        if (load_cnt_r == CW'(N_KERN - 1)) begin
                            load_cnt_r <= {CW{1'b0}};
                            state_r    <= S_COMPUTE;
                        end else begin
                            load_cnt_r <= load_cnt_r + 16'd1;
                        end
                    end
                end
                S_COMPUTE: begin
                    acc_r <= (mac_cnt_r == {CW{1'b0}}) ? prod_ext_s : acc_r + prod_ext_s;
                    if (mac_cnt_r == CW'(N_KERN - 1)) begin
                        mac_cnt_r <= {CW{1'b0}};
                        c_r       <= {CW{1'b0}};
                        i_r       <= {CW{1'b0}};
                        j_r       <= {CW{1'b0}};
                        state_r   <= S_WRITE;
                    end else begin
                        mac_cnt_r <= mac_cnt_r + 16'd1;
                        if (j_r == CW'(K - 1)) begin
                            j_r <= {CW{1'b0}};
                            if (i_r == CW'(K - 1)) begin
                                i_r <= {CW{1'b0}};
                                c_r <= c_r + 16'd1;
                            end else begin
                                i_r <= i_r + 16'd1;
                            end
                        end else begin
                            j_r <= j_r + 16'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (!mem_sel_r) begin
                        mem_sel_r <= 1'b1;
                        mem_w_r   <= 1'b1;
                        address_r <= out_base_r + ADDR_WIDTH'(pix_cnt_r);
                        data_r    <= post_fn(acc_r, shift_r, relu_r);
                    end else if (ready) begin
                        mem_sel_r <= 1'b0;
                        mem_w_r   <= 1'b0;
                        if (pix_cnt_r == CW'(N_PIX - 1)) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= S_DONE;
                        end else begin
                            pix_cnt_r <= pix_cnt_r + 16'd1;
                            if (ox_r == CW'(OUT_W - 1)) begin
                                ox_r <= {CW{1'b0}};
                                oy_r <= oy_r + 16'd1;
                            end else begin
                                ox_r <= ox_r + 16'd1;
                            end
                            state_r <= S_COMPUTE;
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    mem_sel_r <= 1'b0;
                    mem_w_r   <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv2d_mc_with_mem.sv
// Bench for conv2d_mc_with_mem: a memory responder with optional wait states,
// directed test-plan cases, and randomized jobs checked against an arithmetic model.
module tb_conv2d_mc_with_mem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start0, start1, relu;
    logic [7:0]  maddr, kaddr, oaddr;
    logic [4:0]  sh;
    wire  [7:0]  abus0, abus1;
    wire  [31:0] dbus0, dbus1;
    logic        busy0, done0, w0, sel0, rdy0;
    logic        busy1, done1, w1, sel1, rdy1;

    logic [31:0] mem [256];
    int          wait_cfg;
    logic [7:0]  wcnt0;
    logic        noise0;

    int n_cmp = 0, n_fail = 0;
    int done_cnt0 = 0, done_cnt1 = 0, rd_cnt0 = 0;
    int stab_err = 0, gap_err = 0, busy_done_err = 0;
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  exp_a[$];
    logic [31:0] exp_d[$];

    bit          hold0, prev0, prev1, h_w;
    logic [7:0]  h_a;
    logic [31:0] h_d;

    conv2d_mc_with_mem dut0 (
        .clk(clk), .rst(rst), .start(start0), .matrix_addr(maddr), .kernel_addr(kaddr),
        .output_addr(oaddr), .shift(sh), .relu_en(relu), .busy(busy0), .done(done0),
        .mem_w(w0), .mem_sel(sel0), .address_bus(abus0), .data_bus(dbus0), .ready(rdy0));

    conv2d_mc_with_mem #(.C_IN(1), .STRIDE(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .matrix_addr(maddr), .kernel_addr(kaddr),
        .output_addr(oaddr), .shift(sh), .relu_en(relu), .busy(busy1), .done(done1),
        .mem_w(w1), .mem_sel(sel1), .address_bus(abus1), .data_bus(dbus1), .ready(rdy1));

    assign dbus0 = (sel0 && !w0) ? mem[abus0] : 32'bz;
    assign dbus1 = (sel1 && !w1) ? mem[abus1] : 32'bz;
    assign rdy0  = sel0 ? (int'(wcnt0) >= wait_cfg) : noise0;
    assign rdy1  = sel1;

    // Memory responder and bus-protocol monitor.
    always @(posedge clk) begin
        if (sel0 && rdy0 && w0) begin wa_q.push_back(abus0); wd_q.push_back(dbus0); end
        if (sel1 && rdy1 && w1) begin wa_q.push_back(abus1); wd_q.push_back(dbus1); end
        if (sel0 && rdy0 && !w0) rd_cnt0++;
        if (hold0 && !(sel0 && abus0 == h_a && w0 == h_w && (!h_w || dbus0 == h_d))) stab_err++;
        hold0 = sel0 && !rdy0; h_a = abus0; h_w = w0; h_d = dbus0;
        if (prev0 && (sel0 || w0)) gap_err++;
        if (prev1 && (sel1 || w1)) gap_err++;
        prev0 = sel0 && rdy0;
        prev1 = sel1 && rdy1;
        if (done0) begin done_cnt0++; if (busy0) busy_done_err++; end
        if (done1) begin done_cnt1++; if (busy1) busy_done_err++; end
        wcnt0  <= (sel0 && !rdy0) ? wcnt0 + 8'd1 : 8'd0;
        noise0 <= 1'($urandom());
    end

    task automatic put(input int addr, input logic [7:0] v);
        logic [31:0] t;
        t = $urandom();
        mem[addr & 255] = {t[31:8], v};
    endtask

    // Channel 0 = 1..16 row-major, channel 1 = ch1v everywhere, every kernel element = kv.
    task automatic fill_std(input int mb, input int kb, input logic [7:0] ch1v, input logic [7:0] kv);
        for (int i = 0; i < 16; i++) put(mb + i, 8'(i + 1));
        for (int i = 0; i < 16; i++) put(mb + 16 + i, ch1v);
        for (int i = 0; i < 8; i++) put(kb + i, kv);
    endtask

    // Reference convolution straight from the layout and post-processing rules.
    task automatic build_exp(input int cin, input int s, input int mb, input int kb, input int ob,
                             input int shv, input bit rel);
        int ow, oh, oy, ox, acc, r;
        logic signed [7:0] a8, k8;
        exp_a.delete(); exp_d.delete();
        ow = (4 - 2) / s + 1; oh = ow;
        for (int p = 0; p < oh * ow; p++) begin
            oy = p / ow; ox = p % ow; acc = 0;
            for (int c = 0; c < cin; c++)
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++) begin
                        a8 = mem[(mb + c * 16 + (oy * s + i) * 4 + ox * s + j) & 255][7:0];
                        k8 = mem[(kb + c * 4 + i * 2 + j) & 255][7:0];
                        acc += int'(a8) * int'(k8);
                    end
            r = acc >>> shv;
            if (rel && r < 0) r = 0;
            exp_d.push_back(32'(r));
            exp_a.push_back(8'((ob + p) & 255));
        end
    endtask

    task automatic run_job(input int which, output bit to);
        int d0;
        d0 = which ? done_cnt1 : done_cnt0;
        wa_q.delete(); wd_q.delete();
        @(negedge clk);
        if (which == 1) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ((which ? done_cnt1 : done_cnt0) != d0) begin to = 1'b0; break; end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 4;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b%b expected 00", busy0, busy1); end
        if (done0 !== 1'b0 || done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b%b expected 00", done0, done1); end
        if (sel0 !== 1'b0 || sel1 !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b%b expected 00", sel0, sel1); end
        if (w0 !== 1'b0 || w1 !== 1'b0) begin n_fail++; $display("FAIL reset_w: got %b%b expected 00", w0, w1); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_channel;
        int g[9] = '{14, 18, 22, 30, 34, 38, 46, 50, 54};
        bit to; int d0;
        maddr = 8'h10; kaddr = 8'h40; oaddr = 8'h60; sh = 5'd0; relu = 1'b0;
        fill_std(16, 64, 8'd0, 8'd1);
        d0 = done_cnt0;
        run_job(0, to);
        n_cmp += 3;
        if (to) begin n_fail++; $display("FAIL single_timeout: got timeout expected done"); end
        if (wd_q.size() != 9) begin n_fail++; $display("FAIL single_count: got %0d expected 9", wd_q.size()); end
        if (done_cnt0 - d0 != 1) begin n_fail++; $display("FAIL single_done: got %0d expected 1", done_cnt0 - d0); end
        for (int p = 0; p < 9 && p < wd_q.size(); p++) begin
            n_cmp += 2;
            if (wd_q[p] !== 32'(g[p])) begin n_fail++; $display("FAIL single_data[%0d]: got %h expected %h", p, wd_q[p], g[p]); end
            if (wa_q[p] !== 8'(8'h60 + p)) begin n_fail++; $display("FAIL single_addr[%0d]: got %h expected %h", p, wa_q[p], 8'h60 + p); end
        end
    endtask

    task automatic test_multi_channel;
        int g[9] = '{18, 22, 26, 34, 38, 42, 50, 54, 58};
        bit to;
        maddr = 8'h10; kaddr = 8'h40; oaddr = 8'h60; sh = 5'd0; relu = 1'b0;
        fill_std(16, 64, 8'd1, 8'd1);
        run_job(0, to);
        n_cmp += 2;
        if (to) begin n_fail++; $display("FAIL multi_timeout: got timeout expected done"); end
        if (wd_q.size() != 9) begin n_fail++; $display("FAIL multi_count: got %0d expected 9", wd_q.size()); end
        for (int p = 0; p < 9 && p < wd_q.size(); p++) begin
            n_cmp++;
            if (wd_q[p] !== 32'(g[p])) begin n_fail++; $display("FAIL multi_data[%0d]: got %h expected %h", p, wd_q[p], g[p]); end
        end
    endtask

    task automatic test_stride2;
        int g[4] = '{14, 22, 46, 54};
        bit to;
        maddr = 8'h10; kaddr = 8'h40; oaddr = 8'h60; sh = 5'd0; relu = 1'b0;
        fill_std(16, 64, 8'd0, 8'd1);
        run_job(1, to);
        n_cmp += 2;
        if (to) begin n_fail++; $display("FAIL stride_timeout: got timeout expected done"); end
        if (wd_q.size() != 4) begin n_fail++; $display("FAIL stride_count: got %0d expected 4", wd_q.size()); end
        for (int p = 0; p < 4 && p < wd_q.size(); p++) begin
            n_cmp += 2;
            if (wd_q[p] !== 32'(g[p])) begin n_fail++; $display("FAIL stride_data[%0d]: got %h expected %h", p, wd_q[p], g[p]); end
            if (wa_q[p] !== 8'(8'h60 + p)) begin n_fail++; $display("FAIL stride_addr[%0d]: got %h expected %h", p, wa_q[p], 8'h60 + p); end
        end
    endtask

    task automatic test_neg_kernel;
        bit to;
        maddr = 8'h10; kaddr = 8'h40; oaddr = 8'h60; sh = 5'd0; relu = 1'b0;
        fill_std(16, 64, 8'd0, 8'hFF);
        run_job(0, to);
        n_cmp += 2;
        if (to || wd_q.size() != 9) begin n_fail++; $display("FAIL neg_count: got %0d expected 9", wd_q.size()); end
        if (wd_q.size() == 0 || wd_q[0] !== 32'hFFFFFFF2) begin n_fail++; $display("FAIL neg_first: got %h expected fffffff2", wd_q.size() ? wd_q[0] : 32'h0); end
        relu = 1'b1;
        run_job(0, to);
        n_cmp++;
        if (to || wd_q.size() != 9) begin n_fail++; $display("FAIL relu_count: got %0d expected 9", wd_q.size()); end
        for (int p = 0; p < wd_q.size(); p++) begin
            n_cmp++;
            if (wd_q[p] !== 32'd0) begin n_fail++; $display("FAIL relu_data[%0d]: got %h expected 0", p, wd_q[p]); end
        end
        relu = 1'b0; sh = 5'd2;
        fill_std(16, 64, 8'd0, 8'd1);
        run_job(0, to);
        n_cmp++;
        if (to || wd_q.size() == 0 || wd_q[0] !== 32'd3) begin n_fail++; $display("FAIL shift_first: got %h expected 3", wd_q.size() ? wd_q[0] : 32'h0); end
        sh = 5'd0;
    endtask

    task automatic test_wait_states;
        int g[9] = '{14, 18, 22, 30, 34, 38, 46, 50, 54};
        bit to; int s0, gp0;
        maddr = 8'h10; kaddr = 8'h40; oaddr = 8'h60; sh = 5'd0; relu = 1'b0;
        fill_std(16, 64, 8'd0, 8'd1);
        wait_cfg = 3; s0 = stab_err; gp0 = gap_err;
        run_job(0, to);
        wait_cfg = 0;
        n_cmp += 4;
        if (to || wd_q.size() != 9) begin n_fail++; $display("FAIL wait_count: got %0d expected 9", wd_q.size()); end
        if (stab_err != s0) begin n_fail++; $display("FAIL wait_stable: got %0d unstable cycles expected 0", stab_err - s0); end
        if (gap_err != gp0) begin n_fail++; $display("FAIL wait_gap: got %0d missing gaps expected 0", gap_err - gp0); end
        if (busy_done_err != 0) begin n_fail++; $display("FAIL busy_at_done: got %0d expected 0", busy_done_err); end
        for (int p = 0; p < 9 && p < wd_q.size(); p++) begin
            n_cmp++;
            if (wd_q[p] !== 32'(g[p])) begin n_fail++; $display("FAIL wait_data[%0d]: got %h expected %h", p, wd_q[p], g[p]); end
        end
    endtask

    task automatic test_reset_midjob;
        bit to, hit; int r0, d0;
        maddr = 8'h10; kaddr = 8'h40; oaddr = 8'h60; sh = 5'd1; relu = 1'b0;
        fill_std(16, 64, 8'd3, 8'hFE);
        build_exp(2, 1, 16, 64, 96, 1, 1'b0);
        wa_q.delete(); wd_q.delete();
        r0 = rd_cnt0; d0 = done_cnt0; hit = 1'b0;
        @(negedge clk); start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (rd_cnt0 - r0 >= 40) begin hit = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp += 3;
        if (!hit) begin n_fail++; $display("FAIL midrst_loads: got %0d reads expected 40", rd_cnt0 - r0); end
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy0); end
        if (sel0 !== 1'b0 || w0 !== 1'b0) begin n_fail++; $display("FAIL midrst_bus: got sel %b w %b expected 0 0", sel0, w0); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp += 2;
        if (wa_q.size() != 0) begin n_fail++; $display("FAIL midrst_writes: got %0d expected 0", wa_q.size()); end
        if (done_cnt0 != d0) begin n_fail++; $display("FAIL midrst_done: got %0d expected 0", done_cnt0 - d0); end
        run_job(0, to);
        n_cmp++;
        if (to || wd_q.size() != 9) begin n_fail++; $display("FAIL restart_count: got %0d expected 9", wd_q.size()); end
        for (int p = 0; p < 9 && p < wd_q.size(); p++) begin
            n_cmp++;
            if (wd_q[p] !== exp_d[p] || wa_q[p] !== exp_a[p]) begin n_fail++; $display("FAIL restart_data[%0d]: got %h@%h expected %h@%h", p, wd_q[p], wa_q[p], exp_d[p], exp_a[p]); end
        end
    endtask

    task automatic test_start_ignored;
        bit to; int d0;
        maddr = 8'h10; kaddr = 8'h40; oaddr = 8'h80; sh = 5'd0; relu = 1'b0;
        fill_std(16, 64, 8'd1, 8'd1);
        build_exp(2, 1, 16, 64, 128, 0, 1'b0);
        wa_q.delete(); wd_q.delete(); d0 = done_cnt0;
        @(negedge clk); start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        repeat (20) @(negedge clk);
        oaddr = 8'hC0; sh = 5'd3; relu = 1'b1; maddr = 8'h00;
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done_cnt0 != d0) begin to = 1'b0; break; end
        end
        repeat (60) @(negedge clk);
        n_cmp += 2;
        if (to || wd_q.size() != 9) begin n_fail++; $display("FAIL ignore_count: got %0d expected 9", wd_q.size()); end
        if (done_cnt0 - d0 != 1) begin n_fail++; $display("FAIL ignore_done: got %0d expected 1", done_cnt0 - d0); end
        for (int p = 0; p < 9 && p < wd_q.size(); p++) begin
            n_cmp++;
            if (wd_q[p] !== exp_d[p] || wa_q[p] !== exp_a[p]) begin n_fail++; $display("FAIL ignore_data[%0d]: got %h@%h expected %h@%h", p, wd_q[p], wa_q[p], exp_d[p], exp_a[p]); end
        end
        sh = 5'd0; relu = 1'b0;
    endtask

    task automatic test_random;
        bit to; int mb, kb, ob, which;
        for (int it = 0; it < 8; it++) begin
            which = it % 2;
            mb = $urandom_range(0, 255);
            kb = (mb + 32 + $urandom_range(0, 40)) & 255;
            ob = (kb + 8 + $urandom_range(0, 40)) & 255;
            for (int i = 0; i < 32; i++) put(mb + i, 8'($urandom()));
            for (int i = 0; i < 8; i++) put(kb + i, 8'($urandom()));
            maddr = 8'(mb); kaddr = 8'(kb); oaddr = 8'(ob);
            sh = 5'($urandom_range(0, 10)); relu = 1'($urandom());
            wait_cfg = $urandom_range(0, 2);
            build_exp(which ? 1 : 2, which ? 2 : 1, mb, kb, ob, int'(sh), relu);
            run_job(which, to);
            n_cmp++;
            if (to || wd_q.size() != exp_d.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", it, wd_q.size(), exp_d.size()); end
            for (int p = 0; p < exp_d.size() && p < wd_q.size(); p++) begin
                n_cmp++;
                if (wd_q[p] !== exp_d[p] || wa_q[p] !== exp_a[p]) begin n_fail++; $display("FAIL rand%0d_data[%0d]: got %h@%h expected %h@%h", it, p, wd_q[p], wa_q[p], exp_d[p], exp_a[p]); end
            end
        end
        wait_cfg = 0;
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; wait_cfg = 0;
        maddr = 8'h0; kaddr = 8'h0; oaddr = 8'h0; sh = 5'd0; relu = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_single_channel();
        test_multi_channel();
        test_stride2();
        test_neg_kernel();
        test_wait_states();
        test_reset_midjob();
        test_start_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
